// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage.
// Holds the opcode/funct values, field widths, mux-select encodings and the
// packed decoded-entry record that decode_stage and decode_fifo exchange.
package decode_stage_pkg;

    // Field widths
    localparam int W_CPU    = 32;
    localparam int W_REG    = 5;
    localparam int W_OP     = 6;
    localparam int W_FUNCT  = 6;
    localparam int W_IMM    = 16;
    localparam int W_ADDR   = 26;
    localparam int W_ALUOP  = 6;
    localparam int W_PCSRC  = 2;
    localparam int W_MEM    = 2;
    localparam int W_REGSRC = 2;

    // Opcodes
    localparam logic [W_OP-1:0] OP_ZERO  = 6'h00;
    localparam logic [W_OP-1:0] OP_J     = 6'h02;
    localparam logic [W_OP-1:0] OP_JAL   = 6'h03;
    localparam logic [W_OP-1:0] OP_BEQ   = 6'h04;
    localparam logic [W_OP-1:0] OP_BNE   = 6'h05;
    localparam logic [W_OP-1:0] OP_ADDI  = 6'h08;
    localparam logic [W_OP-1:0] OP_ADDIU = 6'h09;
    localparam logic [W_OP-1:0] OP_SLTI  = 6'h0A;
    localparam logic [W_OP-1:0] OP_SLTIU = 6'h0B;
    localparam logic [W_OP-1:0] OP_ANDI  = 6'h0C;
    localparam logic [W_OP-1:0] OP_ORI   = 6'h0D;
    localparam logic [W_OP-1:0] OP_LW    = 6'h23;
    localparam logic [W_OP-1:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [W_FUNCT-1:0] F_JR   = 6'h08;
    localparam logic [W_FUNCT-1:0] F_ADD  = 6'h20;
    localparam logic [W_FUNCT-1:0] F_ADDU = 6'h21;
    localparam logic [W_FUNCT-1:0] F_SUB  = 6'h22;
    localparam logic [W_FUNCT-1:0] F_SUBU = 6'h23;
    localparam logic [W_FUNCT-1:0] F_AND  = 6'h24;
    localparam logic [W_FUNCT-1:0] F_OR   = 6'h25;
    localparam logic [W_FUNCT-1:0] F_XOR  = 6'h26;
    localparam logic [W_FUNCT-1:0] F_NOR  = 6'h27;
    localparam logic [W_FUNCT-1:0] F_SLT  = 6'h2A;
    localparam logic [W_FUNCT-1:0] F_SLTU = 6'h2B;

    // Mux selects
    localparam logic                WEN          = 1'b1;
    localparam logic                WDIS         = 1'b0;
    localparam logic                IMM_ZERO_EXT = 1'b0;
    localparam logic                IMM_SIGN_EXT = 1'b1;
    localparam logic                ALU_SRC_REG  = 1'b0;
    localparam logic                ALU_SRC_IMM  = 1'b1;
    localparam logic [W_PCSRC-1:0]  PC_SRC_NEXT   = 2'd0;
    localparam logic [W_PCSRC-1:0]  PC_SRC_BRANCH = 2'd1;
    localparam logic [W_PCSRC-1:0]  PC_SRC_JUMP   = 2'd2;
    localparam logic [W_PCSRC-1:0]  PC_SRC_JR     = 2'd3;
    localparam logic [W_MEM-1:0]    MEM_NOP   = 2'd0;
    localparam logic [W_MEM-1:0]    MEM_READ  = 2'd1;
    localparam logic [W_MEM-1:0]    MEM_WRITE = 2'd2;
    localparam logic [W_REGSRC-1:0] REG_SRC_ALU = 2'd0;
    localparam logic [W_REGSRC-1:0] REG_SRC_MEM = 2'd1;
    localparam logic [W_REGSRC-1:0] REG_SRC_PC8 = 2'd2;
    localparam logic [W_REG-1:0]    REG_RA      = 5'd31;

    // One decoded instruction as stored in the output buffer
    typedef struct packed {
        logic [W_REG-1:0]    wa;
        logic [W_REG-1:0]    ra1;
        logic [W_REG-1:0]    ra2;
        logic                reg_wen;
        logic                imm_ext;
        logic [W_IMM-1:0]    imm;
        logic [W_ADDR-1:0]   addr;
        logic [W_ALUOP-1:0]  alu_op;
        logic [W_PCSRC-1:0]  pc_src;
        logic [W_MEM-1:0]    mem_cmd;
        logic                alu_src;
        logic [W_REGSRC-1:0] reg_src;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/decode_fifo.sv
// decode_fifo: DEPTH-entry output buffer for decoded instructions.
// Ports: clk/rst_n (async active-low), flush (empties buffer, beats push/pop),
// push/din (write when not full), pop (read when not empty),
// dout (head entry), valid (not empty), full.
module decode_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == CNT_FULL);
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; flush wins over push/pop
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        do_push_s = push && !full;
        do_pop_s  = pop && valid;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes a MIPS-style instruction word and buffers the result.
// Upstream:   inst / in_valid / in_ready, flush drops buffered and incoming work.
// Hazard:     ld_pend / ld_wa block acceptance of an instruction that reads the
//             pending load target; stall_cnt counts those blocked cycles.
// Downstream: out_valid / out_ready plus the decoded fields of the head entry
//             (wa, ra1, ra2, reg_wen, imm_ext, imm, addr, alu_op, pc_src,
//             mem_cmd, alu_src, reg_src, illegal). Fields read 0 while empty.
// Build option: DECODE_HAZARD_EN enables load-use hazard detection and the
//             stall counter; without it hazard is 0 and stall_cnt is 0.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W_CNT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W_CPU-1:0]    inst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    input  logic                ld_pend,
    input  logic [W_REG-1:0]    ld_wa,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W_REG-1:0]    wa,
    output logic [W_REG-1:0]    ra1,
    output logic [W_REG-1:0]    ra2,
    output logic                reg_wen,
    output logic                imm_ext,
    output logic [W_IMM-1:0]    imm,
    output logic [W_ADDR-1:0]   addr,
    output logic [W_ALUOP-1:0]  alu_op,
    output logic [W_PCSRC-1:0]  pc_src,
    output logic [W_MEM-1:0]    mem_cmd,
    output logic                alu_src,
    output logic [W_REGSRC-1:0] reg_src,
    output logic                illegal,
    output logic [W_CNT-1:0]    stall_cnt
);
    logic [W_OP-1:0]    op_s;
    logic [W_FUNCT-1:0] funct_s;
    logic [W_REG-1:0]   rs_s, rt_s, rd_s;
    logic               reads_rt_s;
    logic               hazard_s;
    logic               fifo_valid_s, fifo_full_s;
    logic [$bits(dec_t)-1:0] fifo_dout_s;
    dec_t               dec_s, head_s;

    assign op_s    = inst[31:26];
    assign rs_s    = inst[25:21];
    assign rt_s    = inst[20:16];
    assign rd_s    = inst[15:11];
    assign funct_s = inst[5:0];

    // Combinational decode; alu_op carries funct for R-type, opcode otherwise
    always_comb begin
        dec_s         = '0;
        dec_s.ra1     = rs_s;
        dec_s.ra2     = rt_s;
        dec_s.imm     = inst[15:0];
        dec_s.addr    = inst[25:0];
        dec_s.alu_op  = op_s;
        dec_s.reg_wen = WDIS;
        dec_s.imm_ext = IMM_ZERO_EXT;
        dec_s.pc_src  = PC_SRC_NEXT;
        dec_s.mem_cmd = MEM_NOP;
        dec_s.alu_src = ALU_SRC_REG;
        dec_s.reg_src = REG_SRC_ALU;
        reads_rt_s    = 1'b0;
        case (op_s)
            OP_ZERO: begin
                dec_s.alu_op = funct_s;
                case (funct_s)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU: begin
                        dec_s.wa      = rd_s;
                        dec_s.reg_wen = WEN;
                        reads_rt_s    = 1'b1;
                    end
                    F_JR:    dec_s.pc_src  = PC_SRC_JR;
                    default: dec_s.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
                dec_s.wa      = rt_s;
                dec_s.alu_src = ALU_SRC_IMM;
                dec_s.reg_wen = WEN;
                // Logical immediates zero-extend, arithmetic/compare sign-extend
                if ((op_s == OP_ANDI) || (op_s == OP_ORI)) begin
                    dec_s.imm_ext = IMM_ZERO_EXT;
                end else begin
                    dec_s.imm_ext = IMM_SIGN_EXT;
                end
            end
            OP_LW: begin
                dec_s.wa      = rt_s;
                dec_s.alu_src = ALU_SRC_IMM;
                dec_s.imm_ext = IMM_SIGN_EXT;
                dec_s.mem_cmd = MEM_READ;
                dec_s.reg_src = REG_SRC_MEM;
                dec_s.reg_wen = WEN;
            end
            OP_SW: begin
                dec_s.alu_src = ALU_SRC_IMM;
                dec_s.imm_ext = IMM_SIGN_EXT;
                dec_s.mem_cmd = MEM_WRITE;
                reads_rt_s    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_s.imm_ext = IMM_SIGN_EXT;
                dec_s.pc_src  = PC_SRC_BRANCH;
                reads_rt_s    = 1'b1;
            end
            OP_J:    dec_s.pc_src = PC_SRC_JUMP;
            OP_JAL: begin
                dec_s.pc_src  = PC_SRC_JUMP;
                dec_s.wa      = REG_RA;
                dec_s.reg_src = REG_SRC_PC8;
                dec_s.reg_wen = WEN;
            end
            default: dec_s.illegal = 1'b1;
        endcase
    end

`ifdef DECODE_HAZARD_EN
    logic [W_CNT-1:0] stall_cnt_q, stall_cnt_d;

    // Load-use hazard: pending load targets a register this instruction reads
    always_comb begin
        hazard_s = ld_pend && (ld_wa != '0) &&
                   ((ld_wa == rs_s) || (reads_rt_s && (ld_wa == rt_s)));
    end

    // Saturating count of offered-but-blocked cycles
    always_comb begin
        if (in_valid && hazard_s && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + W_CNT'(1'b1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_s;
    assign hazard_s  = 1'b0;
    assign stall_cnt = '0;
    assign unused_s  = ^{ld_pend, ld_wa, reads_rt_s};
`endif

    assign in_ready = !fifo_full_s && !hazard_s;

    decode_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(dec_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in_valid && in_ready),
        .din   (dec_s),
        .pop   (out_ready),
        .dout  (fifo_dout_s),
        .valid (fifo_valid_s),
        .full  (fifo_full_s)
    );

    // Present the head entry, or all-zero fields while the buffer is empty
    always_comb begin
        if (fifo_valid_s) begin
            head_s = fifo_dout_s;
        end else begin
            head_s = '0;
        end
    end

    assign out_valid = fifo_valid_s;
    assign wa        = head_s.wa;
    assign ra1       = head_s.ra1;
    assign ra2       = head_s.ra2;
    assign reg_wen   = head_s.reg_wen;
    assign imm_ext   = head_s.imm_ext;
    assign imm       = head_s.imm;
    assign addr      = head_s.addr;
    assign alu_op    = head_s.alu_op;
    assign pc_src    = head_s.pc_src;
    assign mem_cmd   = head_s.mem_cmd;
    assign alu_src   = head_s.alu_src;
    assign reg_src   = head_s.reg_src;
    assign illegal   = head_s.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage, checked against a
// queue-based reference model of the decoder and output buffer.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int TB_DEPTH = 4;
    localparam int TB_W_CNT = 4;
`ifdef DECODE_HAZARD_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  wa, ra1, ra2;
        logic        reg_wen, imm_ext;
        logic [15:0] imm;
        logic [25:0] addr;
        logic [5:0]  alu_op;
        logic [1:0]  pc_src, mem_cmd;
        logic        alu_src;
        logic [1:0]  reg_src;
        logic        illegal;
    } exp_t;

    logic clk, rst_n, in_valid, in_ready, flush, ld_pend, out_valid, out_ready;
    logic [31:0] inst;
    logic [4:0]  ld_wa, wa, ra1, ra2;
    logic        reg_wen, imm_ext, alu_src, illegal;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [5:0]  alu_op;
    logic [1:0]  pc_src, mem_cmd, reg_src;
    logic [TB_W_CNT-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t mq[$];
    logic [TB_W_CNT-1:0] m_stall = '0;

    decode_stage #(.DEPTH(TB_DEPTH), .W_CNT(TB_W_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .ld_pend(ld_pend), .ld_wa(ld_wa),
        .out_valid(out_valid), .out_ready(out_ready), .wa(wa), .ra1(ra1),
        .ra2(ra2), .reg_wen(reg_wen), .imm_ext(imm_ext), .imm(imm),
        .addr(addr), .alu_op(alu_op), .pc_src(pc_src), .mem_cmd(mem_cmd),
        .alu_src(alu_src), .reg_src(reg_src), .illegal(illegal),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_alu_funct(input logic [5:0] fn);
        return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    endfunction

    function automatic bit ref_reads_rt(input logic [31:0] i);
        if (i[31:26] == 6'h00) return is_alu_funct(i[5:0]);
        return i[31:26] inside {6'h04, 6'h05, 6'h2B};
    endfunction

    function automatic bit ref_hazard(input logic [31:0] i, input logic lp, input logic [4:0] lw);
        if (!HAZ_EN || !lp || (lw == 5'd0)) return 1'b0;
        return (lw == i[25:21]) || (ref_reads_rt(i) && (lw == i[20:16]));
    endfunction

    // Decoded fields written straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        e = '0;
        e.ra1 = i[25:21]; e.ra2 = i[20:16]; e.imm = i[15:0]; e.addr = i[25:0];
        e.alu_op = op;
        if (op == 6'h00) begin
            e.alu_op = fn;
            if (fn == 6'h08) e.pc_src = PC_SRC_JR;
            else if (is_alu_funct(fn)) begin e.wa = i[15:11]; e.reg_wen = 1'b1; end
            else e.illegal = 1'b1;
        end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D}) begin
            e.wa = i[20:16]; e.alu_src = ALU_SRC_IMM; e.reg_wen = 1'b1;
            e.imm_ext = (op inside {6'h0C, 6'h0D}) ? IMM_ZERO_EXT : IMM_SIGN_EXT;
        end else if (op == 6'h23) begin
            e.wa = i[20:16]; e.alu_src = ALU_SRC_IMM; e.imm_ext = IMM_SIGN_EXT;
            e.mem_cmd = MEM_READ; e.reg_src = REG_SRC_MEM; e.reg_wen = 1'b1;
        end else if (op == 6'h2B) begin
            e.alu_src = ALU_SRC_IMM; e.imm_ext = IMM_SIGN_EXT; e.mem_cmd = MEM_WRITE;
        end else if (op inside {6'h04, 6'h05}) begin
            e.imm_ext = IMM_SIGN_EXT; e.pc_src = PC_SRC_BRANCH;
        end else if (op == 6'h02) begin
            e.pc_src = PC_SRC_JUMP;
        end else if (op == 6'h03) begin
            e.pc_src = PC_SRC_JUMP; e.wa = 5'd31; e.reg_src = REG_SRC_PC8; e.reg_wen = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op_tab [15] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                    6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h23, 6'h2B};
        logic [5:0] fn_tab [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08};
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        int k;
        k  = int'($urandom_range(0, 16));
        op = (k < 15) ? op_tab[k] : 6'($urandom_range(0, 63));
        fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 10)];
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 15));
        if (op == 6'h00) return {op, rs, rt, rd, 5'd0, fn};
        return {op, rs, rt, 16'($urandom())};
    endfunction

    // One clock: check DUT against the model just before the edge, then advance the model
    task automatic step();
        exp_t h, nd;
        bit hz, rdy, do_push, do_pop, fl, iv;
        #1;
        hz  = ref_hazard(inst, ld_pend, ld_wa);
        rdy = (mq.size() < TB_DEPTH) && !hz;
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (mq.size() != 0) begin
            h = mq[0];
            check_eq("wa", 32'(wa), 32'(h.wa));
            check_eq("ra1", 32'(ra1), 32'(h.ra1));
            check_eq("ra2", 32'(ra2), 32'(h.ra2));
            check_eq("reg_wen", 32'(reg_wen), 32'(h.reg_wen));
            check_eq("imm_ext", 32'(imm_ext), 32'(h.imm_ext));
            check_eq("imm", 32'(imm), 32'(h.imm));
            check_eq("addr", 32'(addr), 32'(h.addr));
            check_eq("alu_op", 32'(alu_op), 32'(h.alu_op));
            check_eq("pc_src", 32'(pc_src), 32'(h.pc_src));
            check_eq("mem_cmd", 32'(mem_cmd), 32'(h.mem_cmd));
            check_eq("alu_src", 32'(alu_src), 32'(h.alu_src));
            check_eq("reg_src", 32'(reg_src), 32'(h.reg_src));
            check_eq("illegal", 32'(illegal), 32'(h.illegal));
        end
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && rdy;
        fl      = flush;
        iv      = in_valid;
        nd      = ref_decode(inst);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(nd);
        end
        if (iv && hz && (m_stall != '1)) m_stall = m_stall + 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; ld_pend = 1'b0;
        repeat (TB_DEPTH + 1) step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; inst = 32'd0; in_valid = 1'b0; flush = 1'b0;
        ld_pend = 1'b0; ld_wa = 5'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_stall", 32'(stall_cnt), 32'd0);
        check_eq("rst_ctl", 32'({wa, ra1, ra2, reg_wen, imm_ext, alu_op, pc_src,
                                 mem_cmd, alu_src, reg_src, illegal}), 32'd0);
        check_eq("rst_imm", 32'(imm), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI $9,$0,5
        inst = 32'h2009_0005; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("addi_valid", 32'(out_valid), 32'd1);
        check_eq("addi_wa", 32'(wa), 32'd9);
        check_eq("addi_ra1", 32'(ra1), 32'd0);
        check_eq("addi_imm", 32'(imm), 32'h0005);
        check_eq("addi_ext", 32'(imm_ext), 32'(IMM_SIGN_EXT));
        check_eq("addi_src", 32'(alu_src), 32'(ALU_SRC_IMM));
        check_eq("addi_wen", 32'(reg_wen), 32'd1);
        step();
        drain();

        // ADD $10,$9,$9 behind a load to $9
        ld_pend = 1'b1; ld_wa = 5'd9; inst = 32'h0129_5020; in_valid = 1'b1;
        repeat (3) step();
        check_eq("hz_stall3", 32'(stall_cnt), HAZ_EN ? 32'd3 : 32'd0);
        ld_pend = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("hz_wa", 32'(wa), 32'd10);
        drain();

        // Fill to DEPTH, then one pop
        for (int i = 0; i < TB_DEPTH; i++) begin
            inst = rand_inst(); in_valid = 1'b1;
            step();
        end
        inst = rand_inst();
        #1 check_eq("full_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1 check_eq("pop_ready", 32'(in_ready), 32'd1);
        drain();

        // Flush with two buffered and one incoming
        for (int i = 0; i < 2; i++) begin
            inst = rand_inst(); in_valid = 1'b1;
            step();
        end
        flush = 1'b1; inst = 32'h2009_0007;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        inst = 32'h2011_0042; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("post_flush_imm", 32'(imm), 32'h0042);
        drain();

        // Illegal opcode then JAL
        inst = 32'hFC00_0000; in_valid = 1'b1;
        step();
        inst = 32'h0C00_0010;
        step();
        in_valid = 1'b0;
        check_eq("ill_flag", 32'(illegal), 32'd1);
        check_eq("ill_wen", 32'(reg_wen), 32'd0);
        check_eq("ill_mem", 32'(mem_cmd), 32'(MEM_NOP));
        check_eq("ill_pc", 32'(pc_src), 32'(PC_SRC_NEXT));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("jal_wa", 32'(wa), 32'd31);
        check_eq("jal_pc", 32'(pc_src), 32'(PC_SRC_JUMP));
        check_eq("jal_addr", 32'(addr), 32'h10);
        drain();

        // Reset pulse with two entries buffered and some stall history
        for (int i = 0; i < 2; i++) begin
            inst = 32'h2009_0001 + 32'(i); in_valid = 1'b1;
            step();
        end
        ld_pend = 1'b1; ld_wa = 5'd3; inst = 32'h0060_0020;
        repeat (2) step();
        in_valid = 1'b0; ld_pend = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rstp_valid", 32'(out_valid), 32'd0);
        check_eq("rstp_stall", 32'(stall_cnt), 32'd0);
        check_eq("rstp_ready", 32'(in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        mq.delete();
        m_stall = '0;
        @(negedge clk);
        step();

        // Stall counter saturation
        ld_pend = 1'b1; ld_wa = 5'd5; inst = 32'h00A0_0020; in_valid = 1'b1; out_ready = 1'b1;
        repeat (20) step();
        drain();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            ld_pend   = ($urandom_range(0, 2) == 0);
            ld_wa     = 5'($urandom_range(0, 7));
            inst      = rand_inst();
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
